// File: rtl/rv_dmem_bridge.sv
// ---------------------------------------------------------------------------
// RvDmemBridge -- connects a RISC-V core's data-memory port to a
// Wishbone-style single-transfer bus.
//
// The bridge accepts one load or store at a time. While a bus cycle is
// outstanding, it ignores any new request. A bus cycle ends in one of two ways:
//   - the slave returns bus_ack_i, or
//   - a wait counter reaches the TIMEOUT threshold. The bridge then aborts
//     the cycle and reports the abort on dm_err_o.
//
// Parameters
//   TIMEOUT           cycles to wait for ack before abort (0 = never abort)
//
// Ports
//   clk_i             sole clock, rising edge
//   rst_n_i           synchronous active-low reset
//   dm_addr_i         core byte address
//   dm_data_s_i       core store data (already byte-replicated)
//   dm_data_select_i  byte lane select
//   dm_load_i         load request pulse
//   dm_store_i        store request pulse (wins over a simultaneous load)
//   dm_ready_o        bridge idle, a request this cycle is accepted
//   dm_data_l_o       raw load word, held until the next load completes
//   dm_load_done_o    one-cycle pulse, load finished (normally or aborted)
//   dm_err_o          one-cycle pulse, bus cycle aborted by timeout
//   bus_cyc_o/stb_o   bus cycle / strobe (identical)
//   bus_we_o          write enable
//   bus_adr_o         word-aligned address
//   bus_dat_o         write data
//   bus_sel_o         byte select, forwarded unmodified
//   bus_dat_i         read data
//   bus_ack_i         cycle termination
// ---------------------------------------------------------------------------
module rv_dmem_bridge #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_data_s_i,
    input  logic [3:0]  dm_data_select_i,
    input  logic        dm_load_i,
    input  logic        dm_store_i,
    output logic        dm_ready_o,
    output logic [31:0] dm_data_l_o,
    output logic        dm_load_done_o,
    output logic        dm_err_o,
    output logic        bus_cyc_o,
    output logic        bus_stb_o,
    output logic        bus_we_o,
    output logic [31:0] bus_adr_o,
    output logic [31:0] bus_dat_o,
    output logic [3:0]  bus_sel_o,
    input  logic [31:0] bus_dat_i,
    input  logic        bus_ack_i
);

    typedef enum logic {
        IDLE,
        BUS
    } state_e;

    // The counter is compared against TIMEOUT-1. This gives exactly
    // TIMEOUT strobe cycles before an abort.
    localparam logic [7:0] TO_LAST = 8'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_e      state_q;
    logic [31:0] adr_q;
    logic [31:0] wdat_q;
    logic [31:0] rdat_q;
    logic [3:0]  sel_q;
    logic        we_q;
    logic [7:0]  waitCnt_q;
    logic        done_q;
    logic        err_q;

    logic        request;
    logic        timeoutHit;
    logic [31:0] wordAddr;

    assign request    = dm_load_i | dm_store_i;
    assign wordAddr   = dm_addr_i & 32'hFFFF_FFFC;
    assign timeoutHit = (TIMEOUT != 0) && (waitCnt_q == TO_LAST);

    // The FSM also produces every registered output.
    // An ack in the threshold cycle is checked first, so the ack wins
    // over the timeout.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            adr_q     <= '0;
            wdat_q    <= '0;
            rdat_q    <= '0;
            sel_q     <= '0;
            we_q      <= 1'b0;
            waitCnt_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (request) begin
                        state_q   <= BUS;
                        adr_q     <= wordAddr;
                        wdat_q    <= dm_data_s_i;
                        sel_q     <= dm_data_select_i;
                        we_q      <= dm_store_i;
                        waitCnt_q <= '0;
                    end
                end
                BUS: begin
                    if (bus_ack_i) begin
                        state_q <= IDLE;
                        if (!we_q) begin
                            done_q <= 1'b1;
                            rdat_q <= bus_dat_i;
                        end
                    end else if (timeoutHit) begin
                        state_q <= IDLE;
                        err_q   <= 1'b1;
                        if (!we_q) begin
                            done_q <= 1'b1;
                            rdat_q <= '0;
                        end
                    end else begin
                        waitCnt_q <= waitCnt_q + 8'd1;
                    end
                end
            endcase
        end
    end

    assign dm_ready_o     = (state_q == IDLE);
    assign bus_cyc_o      = (state_q == BUS);
    assign bus_stb_o      = (state_q == BUS);
    assign bus_we_o       = we_q;
    assign bus_adr_o      = adr_q;
    assign bus_dat_o      = wdat_q;
    assign bus_sel_o      = sel_q;
    assign dm_data_l_o    = rdat_q;
    assign dm_load_done_o = done_q;
    assign dm_err_o       = err_q;

endmodule

// File: tb/tb_rv_dmem_bridge.sv
// ---------------------------------------------------------------------------
// Testbench for rv_dmem_bridge (TIMEOUT = 4).
//
// The bench drives each transaction from a record. The record holds the
// request, the ack delay and the expected bus and core-side outcome.
// Fixed records cover the documented scenarios. Random records get their
// expectations from transaction-level arithmetic:
//   - number of strobe cycles
//   - whether the cycle aborts
//   - which load word becomes visible
// Reset corner cases are written out by hand.
// ---------------------------------------------------------------------------
module tb_rv_dmem_bridge;

    localparam int TO = 4;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [31:0] dm_addr_i;
    logic [31:0] dm_data_s_i;
    logic [3:0]  dm_data_select_i;
    logic        dm_load_i;
    logic        dm_store_i;
    logic        dm_ready_o;
    logic [31:0] dm_data_l_o;
    logic        dm_load_done_o;
    logic        dm_err_o;
    logic        bus_cyc_o;
    logic        bus_stb_o;
    logic        bus_we_o;
    logic [31:0] bus_adr_o;
    logic [31:0] bus_dat_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_dat_i;
    logic        bus_ack_i;

    int compared   = 0;
    int mismatched = 0;
    logic [31:0] lastDataL;

    typedef struct {
        logic        isLoad;
        logic        isStore;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        int          ackDelay;
        logic [31:0] rdata;
        logic        spurious;
        logic [31:0] expAdr;
        logic        expWe;
        int          expStb;
        logic        expErr;
        logic        expDone;
        logic [31:0] expDataL;
    } vec_t;

    vec_t table_v[7];

    rv_dmem_bridge #(.TIMEOUT(TO)) dut (
        .clk_i            (clk_i),
        .rst_n_i          (rst_n_i),
        .dm_addr_i        (dm_addr_i),
        .dm_data_s_i      (dm_data_s_i),
        .dm_data_select_i (dm_data_select_i),
        .dm_load_i        (dm_load_i),
        .dm_store_i       (dm_store_i),
        .dm_ready_o       (dm_ready_o),
        .dm_data_l_o      (dm_data_l_o),
        .dm_load_done_o   (dm_load_done_o),
        .dm_err_o         (dm_err_o),
        .bus_cyc_o        (bus_cyc_o),
        .bus_stb_o        (bus_stb_o),
        .bus_we_o         (bus_we_o),
        .bus_adr_o        (bus_adr_o),
        .bus_dat_o        (bus_dat_o),
        .bus_sel_o        (bus_sel_o),
        .bus_dat_i        (bus_dat_i),
        .bus_ack_i        (bus_ack_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Step one clock edge and settle a little past it.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Run one transaction from an idle bridge and check every cycle of it.
    task automatic applyStimulus(input string tag, input vec_t v);
        checkOutput($sformatf("%s idle ready", tag), 32'(dm_ready_o), 32'd1);
        dm_load_i        = v.isLoad;
        dm_store_i       = v.isStore;
        dm_addr_i        = v.addr;
        dm_data_s_i      = v.wdata;
        dm_data_select_i = v.sel;
        bus_ack_i        = 1'b0;
        step();
        // Scramble core inputs so bus outputs must come from the captured copy.
        dm_load_i        = 1'b0;
        dm_store_i       = 1'b0;
        dm_addr_i        = $urandom;
        dm_data_s_i      = $urandom;
        dm_data_select_i = 4'($urandom);
        for (int k = 1; k <= v.expStb; k++) begin
            checkOutput($sformatf("%s s%0d cyc", tag, k), 32'(bus_cyc_o), 32'd1);
            checkOutput($sformatf("%s s%0d stb", tag, k), 32'(bus_stb_o), 32'd1);
            checkOutput($sformatf("%s s%0d we", tag, k), 32'(bus_we_o), 32'(v.expWe));
            checkOutput($sformatf("%s s%0d adr", tag, k), bus_adr_o, v.expAdr);
            checkOutput($sformatf("%s s%0d dat", tag, k), bus_dat_o, v.wdata);
            checkOutput($sformatf("%s s%0d sel", tag, k), 32'(bus_sel_o), 32'(v.sel));
            checkOutput($sformatf("%s s%0d ready", tag, k), 32'(dm_ready_o), 32'd0);
            checkOutput($sformatf("%s s%0d done", tag, k), 32'(dm_load_done_o), 32'd0);
            checkOutput($sformatf("%s s%0d err", tag, k), 32'(dm_err_o), 32'd0);
            if (v.spurious && k == 1) dm_load_i = 1'b1;
            bus_ack_i = (k == v.ackDelay + 1);
            bus_dat_i = bus_ack_i ? v.rdata : $urandom;
            step();
            dm_load_i = 1'b0;
        end
        bus_ack_i = 1'b0;
        checkOutput($sformatf("%s end cyc", tag), 32'(bus_cyc_o), 32'd0);
        checkOutput($sformatf("%s end ready", tag), 32'(dm_ready_o), 32'd1);
        checkOutput($sformatf("%s end done", tag), 32'(dm_load_done_o), 32'(v.expDone));
        checkOutput($sformatf("%s end err", tag), 32'(dm_err_o), 32'(v.expErr));
        checkOutput($sformatf("%s end dataL", tag), dm_data_l_o, v.expDataL);
        // A stray ack while idle must not start or finish anything.
        bus_ack_i = 1'b1;
        bus_dat_i = $urandom;
        step();
        bus_ack_i = 1'b0;
        checkOutput($sformatf("%s post cyc", tag), 32'(bus_cyc_o), 32'd0);
        checkOutput($sformatf("%s post done", tag), 32'(dm_load_done_o), 32'd0);
        checkOutput($sformatf("%s post err", tag), 32'(dm_err_o), 32'd0);
        checkOutput($sformatf("%s post dataL", tag), dm_data_l_o, v.expDataL);
    endtask

    initial begin
        vec_t v;
        int   r;

        rst_n_i          = 1'b0;
        dm_addr_i        = '0;
        dm_data_s_i      = '0;
        dm_data_select_i = '0;
        dm_load_i        = 1'b0;
        dm_store_i       = 1'b0;
        bus_dat_i        = '0;
        bus_ack_i        = 1'b0;

        //                 ld    st    addr          wdata         sel      dly rdata         spur  expAdr        we    stb err   done  dataL
        table_v[0] = '{1'b1, 1'b0, 32'h1000_0006, 32'h0000_0000, 4'b1100, 0,  32'hA5A5_1234, 1'b0, 32'h1000_0004, 1'b0, 1, 1'b0, 1'b1, 32'hA5A5_1234};
        table_v[1] = '{1'b0, 1'b1, 32'h0000_0020, 32'h1122_3344, 4'b1111, 3,  32'h0000_0000, 1'b0, 32'h0000_0020, 1'b1, 4, 1'b0, 1'b0, 32'hA5A5_1234};
        table_v[2] = '{1'b1, 1'b0, 32'h0000_0040, 32'h7777_7777, 4'b1111, 99, 32'h0000_0000, 1'b0, 32'h0000_0040, 1'b0, 4, 1'b1, 1'b1, 32'h0000_0000};
        table_v[3] = '{1'b1, 1'b0, 32'h0000_0047, 32'h0000_0000, 4'b0011, 3,  32'hDEAD_BEEF, 1'b0, 32'h0000_0044, 1'b0, 4, 1'b0, 1'b1, 32'hDEAD_BEEF};
        table_v[4] = '{1'b1, 1'b1, 32'h0000_0103, 32'h55AA_55AA, 4'b0000, 1,  32'h1234_5678, 1'b0, 32'h0000_0100, 1'b1, 2, 1'b0, 1'b0, 32'hDEAD_BEEF};
        table_v[5] = '{1'b1, 1'b0, 32'h0000_0200, 32'h0000_0000, 4'b0000, 2,  32'h0BAD_F00D, 1'b1, 32'h0000_0200, 1'b0, 3, 1'b0, 1'b1, 32'h0BAD_F00D};
        table_v[6] = '{1'b0, 1'b1, 32'h0000_0030, 32'hCAFE_F00D, 4'b0101, 99, 32'h0000_0000, 1'b0, 32'h0000_0030, 1'b1, 4, 1'b1, 1'b0, 32'h0BAD_F00D};

        // Reset state.
        step();
        step();
        checkOutput("rst ready", 32'(dm_ready_o), 32'd1);
        checkOutput("rst cyc", 32'(bus_cyc_o), 32'd0);
        checkOutput("rst stb", 32'(bus_stb_o), 32'd0);
        checkOutput("rst we", 32'(bus_we_o), 32'd0);
        checkOutput("rst done", 32'(dm_load_done_o), 32'd0);
        checkOutput("rst err", 32'(dm_err_o), 32'd0);
        checkOutput("rst dataL", dm_data_l_o, 32'd0);
        checkOutput("rst adr", bus_adr_o, 32'd0);
        checkOutput("rst dat", bus_dat_o, 32'd0);
        checkOutput("rst sel", 32'(bus_sel_o), 32'd0);
        rst_n_i = 1'b1;
        step();

        for (int i = 0; i < 7; i++) begin
            applyStimulus($sformatf("vec%0d", i), table_v[i]);
        end

        // Reset during the second wait cycle of a load, followed by a late ack.
        dm_load_i        = 1'b1;
        dm_addr_i        = 32'h0000_0080;
        dm_data_select_i = 4'b1111;
        step();
        dm_load_i = 1'b0;
        checkOutput("midrst w1 cyc", 32'(bus_cyc_o), 32'd1);
        step();
        checkOutput("midrst w2 cyc", 32'(bus_cyc_o), 32'd1);
        rst_n_i = 1'b0;
        step();
        checkOutput("midrst cyc", 32'(bus_cyc_o), 32'd0);
        checkOutput("midrst ready", 32'(dm_ready_o), 32'd1);
        checkOutput("midrst done", 32'(dm_load_done_o), 32'd0);
        checkOutput("midrst err", 32'(dm_err_o), 32'd0);
        checkOutput("midrst adr", bus_adr_o, 32'd0);
        checkOutput("midrst dataL", dm_data_l_o, 32'd0);
        rst_n_i   = 1'b1;
        bus_ack_i = 1'b1;
        bus_dat_i = 32'h0000_0123;
        step();
        bus_ack_i = 1'b0;
        checkOutput("lateack cyc", 32'(bus_cyc_o), 32'd0);
        checkOutput("lateack done", 32'(dm_load_done_o), 32'd0);
        checkOutput("lateack err", 32'(dm_err_o), 32'd0);
        checkOutput("lateack ready", 32'(dm_ready_o), 32'd1);
        checkOutput("lateack dataL", dm_data_l_o, 32'd0);

        // A request that coincides with reset is dropped.
        rst_n_i    = 1'b0;
        dm_store_i = 1'b1;
        dm_addr_i  = 32'h0000_0090;
        step();
        rst_n_i    = 1'b1;
        dm_store_i = 1'b0;
        checkOutput("rstreq cyc", 32'(bus_cyc_o), 32'd0);
        checkOutput("rstreq ready", 32'(dm_ready_o), 32'd1);
        step();
        checkOutput("rstreq cyc2", 32'(bus_cyc_o), 32'd0);
        checkOutput("rstreq we", 32'(bus_we_o), 32'd0);
        lastDataL = 32'd0;

        // Randomized transactions with expectations from transaction-level rules.
        for (int i = 0; i < 60; i++) begin
            r          = $urandom_range(1, 3);
            v.isLoad   = r[0];
            v.isStore  = r[1];
            v.addr     = $urandom;
            v.wdata    = $urandom;
            v.sel      = 4'($urandom);
            v.ackDelay = $urandom_range(0, 6);
            v.rdata    = $urandom;
            v.spurious = 1'($urandom);
            v.expAdr   = {v.addr[31:2], 2'b00};
            v.expWe    = v.isStore;
            v.expErr   = (v.ackDelay >= TO);
            v.expStb   = v.expErr ? TO : v.ackDelay + 1;
            v.expDone  = !v.isStore;
            if (v.expDone) lastDataL = v.expErr ? 32'd0 : v.rdata;
            v.expDataL = lastDataL;
            applyStimulus($sformatf("rnd%0d", i), v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/rv_dmem_bridge.md
RV_DMEM_BRIDGE -- requirements
Module: rv_dmem_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: cycles to wait for bus_ack_i before abort; 0 disables the timeout; legal range 0..255.
REQ-002 SHALL have clk_i  in  1  sole clock; all logic on its rising edge.
REQ-003 SHALL have rst_n_i  in  1  reset, synchronous, active-low.
REQ-004 SHALL have dm_addr_i  in  32  core data address.
REQ-005 SHALL have dm_data_s_i  in  32  core store data, byte-replicated by the core.
REQ-006 SHALL have dm_data_select_i  in  4  byte lane select.
REQ-007 SHALL have dm_load_i  in  1  load request, single-cycle pulse.
REQ-008 SHALL have dm_store_i  in  1  store request, single-cycle pulse.
REQ-009 SHALL have dm_ready_o  out  1  high when a new request is accepted this cycle.
REQ-010 SHALL have dm_data_l_o  out  32  raw load word, no sign extension.
REQ-011 SHALL have dm_load_done_o  out  1  one-cycle pulse; dm_data_l_o valid.
REQ-012 SHALL have dm_err_o  out  1  one-cycle pulse on a timeout abort.
REQ-013 SHALL have bus_cyc_o / bus_stb_o  out  1 each  bus cycle and strobe, always equal.
REQ-014 SHALL have bus_we_o  out  1  write enable.
REQ-015 SHALL have bus_adr_o  out  32  word address: dm_addr_i with bits [1:0] forced to 0.
REQ-016 SHALL have bus_dat_o  out  32  write data.
REQ-017 SHALL have bus_sel_o  out  4  byte select.
REQ-018 SHALL have bus_dat_i  in  32  read data.
REQ-019 SHALL have bus_ack_i  in  1  cycle termination.

Function
REQ-020 SHALL implement FSM IDLE, BUS; dm_ready_o = (state == IDLE), combinational from state only.
REQ-021 In IDLE, dm_store_i or dm_load_i SHALL register the request:
- address, data, select
- we = dm_store_i
- next state BUS; bus_cyc_o / bus_stb_o high from the next cycle.
REQ-022 Simultaneous dm_load_i and dm_store_i SHALL be treated as a store.
REQ-023 Requests while in BUS SHALL be ignored; no queuing.
REQ-024 In BUS, all bus_* outputs SHALL hold stable until termination.
REQ-025 In BUS with bus_ack_i high:
- next cycle: bus_cyc_o / bus_stb_o low, state IDLE
- load: bus_dat_i captured into dm_data_l_o, dm_load_done_o pulses for one cycle in the same cycle dm_ready_o rises
- store: no done pulse.
REQ-026 Latency: request at cycle N, bus strobe from N+1; with ack at cycle M, ready/done at M+1; minimum request-to-done is 2 cycles.
REQ-027 An 8-bit wait counter SHALL clear on entry to BUS and increment each BUS cycle without ack.
REQ-028 If TIMEOUT != 0 and the counter reaches TIMEOUT-1 without ack:
- next cycle: abort, state IDLE, strobe low
- dm_err_o pulses
- load: dm_load_done_o pulses with dm_data_l_o = 0.
REQ-029 An ack arriving in the same cycle as the timeout threshold SHALL win: normal completion, no error.
REQ-030 bus_ack_i in IDLE SHALL be ignored.
REQ-031 dm_data_l_o SHALL hold its last value until the next load completes.
REQ-032 bus_sel_o SHALL be forwarded unmodified for loads and stores, including 4'b0000.

Reset
REQ-033 While rst_n_i is low at a clock edge, the block SHALL reset as follows:
- state = IDLE, dm_ready_o = 1
- bus_cyc_o = bus_stb_o = bus_we_o = 0
- dm_load_done_o = dm_err_o = 0
- dm_data_l_o = 0, counter = 0
- bus_adr_o, bus_dat_o, bus_sel_o = 0.
REQ-034 Reset asserted mid-transaction SHALL:
- drop bus_cyc_o at that edge
- discard the transaction with no done or err pulse
- ignore a late ack after reset.
REQ-035 A request pulse coincident with rst_n_i low SHALL be discarded.

Verification
REQ-036 Load 0x1000_0006, sel 4'b1100, ack on first strobe cycle with data 0xA5A5_1234 -> bus_adr_o 0x1000_0004, we 0; next cycle dm_load_done_o = 1, dm_data_l_o = 0xA5A5_1234, dm_ready_o = 1.
REQ-037 Store 0x20 data 0x1122_3344 sel 4'b1111, ack after 3 wait cycles -> strobe high 4 cycles with we = 1; ready returns one cycle after ack; no done pulse.
REQ-038 TIMEOUT = 4, load with no ack -> strobe high exactly 4 cycles; then dm_err_o and dm_load_done_o pulse together with dm_data_l_o = 0.
REQ-039 TIMEOUT = 4, ack on the 4th strobe cycle -> normal completion, dm_err_o stays 0.
REQ-040 Second load pulse during BUS, plus simultaneous load and store in IDLE -> second load produces no bus cycle; simultaneous request yields one cycle with bus_we_o = 1.
REQ-041 rst_n_i low for one cycle during the 2nd wait cycle of a load -> bus_cyc_o low next cycle; following ack ignored; no pulses; dm_ready_o = 1.
